// File: rtl/rgb565_grayscale_pkg.sv
// Shared types and constants for the RGB565 luminance custom-instruction unit.
package rgb565_grayscale_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_GRAY   = 2'd0;
    localparam logic [1:0] MODE_THRESH = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;

    localparam logic [15:0] W_R = 16'd54;
    localparam logic [15:0] W_G = 16'd183;
    localparam logic [15:0] W_B = 16'd19;

    localparam int LANE_W = 8;

endpackage

// File: rtl/rgb565_to_gray_pixel.sv
// One RGB565 pixel to an 8-bit lane: luminance, then the selected output mode.
module rgb565_to_gray_pixel
    import rgb565_grayscale_pkg::*;
(
    input  logic [15:0]       pixel_i,
    input  logic [1:0]        mode_i,
    input  logic [LANE_W-1:0] threshold_i,
    output logic [LANE_W-1:0] gray_o
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    logic [7:0]  gray;

    assign r8 = {pixel_i[15:11], pixel_i[15:13]};
    assign g8 = {pixel_i[10:5], pixel_i[10:9]};
    assign b8 = {pixel_i[4:0], pixel_i[4:2]};

    // Weights sum to 256, so the 16-bit sum never overflows.
    assign sum = W_R * {8'd0, r8}
               + W_G * {8'd0, g8}
               + W_B * {8'd0, b8};

    assign gray = 8'(sum >> 8);

    always_comb begin
        gray_o = gray;
        unique case (1'b1)
            (mode_i == MODE_THRESH):
                gray_o = (gray >= threshold_i) ? 8'hFF : 8'h00;
            (mode_i == MODE_INVERT):
                gray_o = 8'hFF - gray;
            default:
                gray_o = gray;
        endcase
    end

endmodule

// File: rtl/rgb565_grayscale_multi_ise.sv
// Custom-instruction unit: four RGB565 pixels in, four packed luminance bytes out.
module rgb565_grayscale_multi_ise
    import rgb565_grayscale_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd13,
    parameter int         PIXELS_PER_CYCLE    = 1,
    parameter logic [7:0] DEFAULT_THRESHOLD   = 8'd128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int PPC   = PIXELS_PER_CYCLE;
    localparam int STEPS = (PPC == 1) ? 4 : (PPC == 2) ? 2 : 1;
    localparam int LW    = LANE_W * PPC;
    localparam int PW    = 16 * PPC;

    localparam logic [7:0] CFG_ID   = customInstructionId + 8'd1;
    localparam logic [1:0] LAST_CNT = 2'(STEPS - 1);

    if (PPC != 1 && PPC != 2 && PPC != 4) begin : g_bad_ppc
        $error("PIXELS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t      state_q, state_d;
    logic [63:0] pix_q, pix_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  thr_q, thr_d;

    logic [LW-1:0]    lanes;
    logic [32+LW-1:0] shifted;

    // Lowest pending pixels always sit at the bottom of pix_q.
    for (genvar k = 0; k < PPC; k++) begin : g_pix
        rgb565_to_gray_pixel u_pix (
            .pixel_i     (pix_q[16*k +: 16]),
            .mode_i      (mode_q),
            .threshold_i (thr_q),
            .gray_o      (lanes[LANE_W*k +: LANE_W])
        );
    end

    // New lanes enter at the top; after the last step pixel0 lands in byte 0.
    assign shifted = {lanes, res_q};

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        case (state_q)
            S_IDLE: begin
                if (start && iseId == customInstructionId) begin
                    pix_d   = {valueB, valueA};
                    cnt_d   = LAST_CNT;
                    state_d = S_BUSY;
                end else if (start && iseId == CFG_ID) begin
                    res_d   = {16'd0, thr_q, 6'd0, mode_q};
                    mode_d  = valueA[1:0];
                    thr_d   = valueA[15:8];
                    state_d = S_DONE;
                end
            end
            S_BUSY: begin
                pix_d = pix_q >> PW;
                res_d = 32'(shifted >> LW);
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_GRAY;
            thr_q   <= DEFAULT_THRESHOLD;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
        end
    end

    assign done   = (state_q == S_DONE);
    assign result = done ? res_q : 32'd0;

endmodule

// File: tb/tb_rgb565_grayscale_multi_ise.sv
// Bench: three unit instances (1, 2, 4 pixels/clock) driven in lockstep.
module tb_rgb565_grayscale_multi_ise;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  iseId = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;

    logic        done1, done2, done4;
    logic [31:0] res1, res2, res4;

    always #5 clock = ~clock;

    rgb565_grayscale_multi_ise #(.PIXELS_PER_CYCLE(1)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done1), .result(res1)
    );
    rgb565_grayscale_multi_ise #(.PIXELS_PER_CYCLE(2)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done2), .result(res2)
    );
    rgb565_grayscale_multi_ise #(.PIXELS_PER_CYCLE(4)) u4 (
        .clock(clock), .reset_n(reset_n), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done4), .result(res4)
    );

    logic        dv[3];
    logic [31:0] rv[3];
    assign dv[0] = done1;
    assign dv[1] = done2;
    assign dv[2] = done4;
    assign rv[0] = res1;
    assign rv[1] = res2;
    assign rv[2] = res4;

    int errors = 0;
    int checks = 0;

    int          lat[3];
    int          npulse[3];
    bit          leak[3];
    logic [31:0] got[3];
    int          ppc_of[3] = '{1, 2, 4};

    logic [1:0] mm = 2'd0;
    logic [7:0] mt = 8'd128;

    typedef struct {
        bit          cfg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: channel expansion by bit replication, then weighted mean.
    function automatic logic [7:0] model_pix(input logic [15:0] p,
                                             input logic [1:0] m,
                                             input logic [7:0] t);
        int r, g, b, r8, g8, b8, y;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]);
        b  = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        y  = (54 * r8 + 183 * g8 + 19 * b8) / 256;
        if (m == 2'd1) y = (y >= int'(t)) ? 255 : 0;
        else if (m == 2'd2) y = 255 - y;
        return 8'(y);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [1:0] m,
                                               input logic [7:0] t);
        return {model_pix(b[31:16], m, t), model_pix(b[15:0], m, t),
                model_pix(a[31:16], m, t), model_pix(a[15:0], m, t)};
    endfunction

    task automatic run_op(input logic [7:0] id, input logic [31:0] a,
                          input logic [31:0] b, input bit collide,
                          input logic [31:0] a2, input logic [31:0] b2);
        @(negedge clock);
        start  = 1'b1;
        iseId  = id;
        valueA = a;
        valueB = b;
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; npulse[i] = 0; leak[i] = 1'b0; got[i] = 32'd0;
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (dv[i]) begin
                    npulse[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = c;
                        got[i] = rv[i];
                    end
                end else if (rv[i] != 32'd0) begin
                    leak[i] = 1'b1;
                end
            end
            start = 1'b0;
            if (collide && c == 1) begin
                start  = 1'b1;
                iseId  = id;
                valueA = a2;
                valueB = b2;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input bit cfg,
                            input logic [31:0] exp);
        int el;
        for (int i = 0; i < 3; i++) begin
            el = cfg ? 1 : 4 / ppc_of[i] + 1;
            chk($sformatf("%s/ppc%0d result", tag, ppc_of[i]), got[i], exp);
            chk($sformatf("%s/ppc%0d latency", tag, ppc_of[i]),
                32'(lat[i]), 32'(el));
            chk($sformatf("%s/ppc%0d pulses", tag, ppc_of[i]),
                32'(npulse[i]), 32'd1);
            chk($sformatf("%s/ppc%0d idle_result", tag, ppc_of[i]),
                32'(leak[i]), 32'd0);
        end
    endtask

    task automatic do_vec(input string tag, input bit cfg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        run_op(cfg ? 8'd14 : 8'd13, a, b, 1'b0, 32'd0, 32'd0);
        check_op(tag, cfg, exp);
        if (cfg) begin
            mm = a[1:0];
            mt = a[15:8];
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h07E0F800, 32'h001FFFFF, 32'h12FFB635};
        tbl[1]  = '{1'b1, 32'h00008001, 32'h00000000, 32'h00008000};
        tbl[2]  = '{1'b0, 32'h07E0F800, 32'h001FFFFF, 32'h00FFFF00};
        tbl[3]  = '{1'b1, 32'h00000002, 32'h00000000, 32'h00008001};
        tbl[4]  = '{1'b0, 32'h07E0F800, 32'h001FFFFF, 32'hED0049CA};
        tbl[5]  = '{1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        tbl[6]  = '{1'b1, 32'h00000001, 32'h00000000, 32'h00000002};
        tbl[7]  = '{1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        tbl[8]  = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF};
        tbl[9]  = '{1'b1, 32'h0000FF01, 32'h00000000, 32'h00000001};
        tbl[10] = '{1'b0, 32'hF7DEFFFF, 32'h00000000, 32'h000000FF};
        tbl[11] = '{1'b1, 32'h00000000, 32'h00000000, 32'h0000FF01};

        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset/ppc%0d done", ppc_of[i]), 32'(dv[i]), 32'd0);
            chk($sformatf("reset/ppc%0d result", ppc_of[i]), rv[i], 32'd0);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_op(8'd47, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("badid/ppc%0d pulses", ppc_of[i]),
                32'(npulse[i]), 32'd0);
            chk($sformatf("badid/ppc%0d result", ppc_of[i]),
                32'(leak[i]), 32'd0);
        end

        for (int n = 0; n < 12; n++) begin
            do_vec($sformatf("tbl%0d", n), tbl[n].cfg, tbl[n].a,
                   tbl[n].b, tbl[n].exp);
        end

        // Abort a convert with reset while busy.
        @(negedge clock);
        start = 1'b1; iseId = 8'd13;
        valueA = 32'h07E0F800; valueB = 32'h001FFFFF;
        @(negedge clock);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort/ppc%0d done", ppc_of[i]), 32'(dv[i]), 32'd0);
            chk($sformatf("abort/ppc%0d result", ppc_of[i]), rv[i], 32'd0);
            npulse[i] = 0;
        end
        @(negedge clock);
        reset_n = 1'b1;
        mm = 2'd0;
        mt = 8'd128;
        repeat (8) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (dv[i]) npulse[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort/ppc%0d pulses", ppc_of[i]),
                32'(npulse[i]), 32'd0);
        end

        // Second start while busy must be ignored.
        run_op(8'd13, 32'h07E0F800, 32'h001FFFFF, 1'b1,
               32'h00000000, 32'h00000000);
        check_op("collide", 1'b0, 32'h12FFB635);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3) == 0) begin
                do_vec($sformatf("rcfg%0d", n), 1'b1, a, b,
                       {16'd0, mt, 6'd0, mm});
            end else begin
                do_vec($sformatf("rcnv%0d", n), 1'b0, a, b,
                       model_word(a, b, mm, mt));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
